// File: rtl/i2c_seq_engine_if.sv
`default_nettype none
// ============================================================================
// Module  : i2c_seq_engine_if
// Brief   : Single-outstanding register request/ack bus toward the AXI-lite master.
// Rev     : 1.0
// ============================================================================
interface i2c_seq_engine_if #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32
);
   logic                      seq_axi_wr_req;
   logic                      seq_axi_rd_req;
   logic [AXI_ADDR_WIDTH-1:0] seq_axi_addr;
   logic [AXI_DATA_WIDTH-1:0] seq_axi_wdata;
   logic                      seq_axi_ack;
   logic [AXI_DATA_WIDTH-1:0] seq_axi_rdata;

   modport master (
      output seq_axi_wr_req, seq_axi_rd_req, seq_axi_addr, seq_axi_wdata,
      input  seq_axi_ack, seq_axi_rdata
   );

   modport slave (
      input  seq_axi_wr_req, seq_axi_rd_req, seq_axi_addr, seq_axi_wdata,
      output seq_axi_ack, seq_axi_rdata
   );
endinterface
`default_nettype wire

// File: rtl/i2c_seq_engine.sv
`default_nettype none
// ============================================================================
// Module  : i2c_seq_engine
// Brief   : ROM-driven I2C write/read sequencer for the AXI I2C IP.
// Rev     : 1.0
// ============================================================================
module i2c_seq_engine #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int CMD_ADDR_WIDTH = 10,
   parameter int DELAY_CYCLES   = 4096,
   parameter int POLL_LIMIT     = 65535
) (
   input  wire logic                      aclk,
   input  wire logic                      areset,
   input  wire logic                      start_pulse,
   input  wire logic [CMD_ADDR_WIDTH-1:0] start_addr,
   output logic      [CMD_ADDR_WIDTH-1:0] cmd_addr,
   input  wire logic [15:0]               cmd_data,
   i2c_seq_engine_if.master               axi,
   output logic                           rd_valid,
   output logic      [7:0]                rd_data,
   output logic                           busy,
   output logic                           done,
   output logic                           error,
   output logic      [1:0]                err_code,
   output logic      [7:0]                xfer_count
);

   localparam int c_POLL_W = $clog2(POLL_LIMIT + 1);
   localparam int c_DLY_W  = $clog2(DELAY_CYCLES + 1);

   localparam logic [11:0] c_REG_ISR  = 12'h020;
   localparam logic [11:0] c_REG_CR   = 12'h100;
   localparam logic [11:0] c_REG_SR   = 12'h104;
   localparam logic [11:0] c_REG_TX   = 12'h108;
   localparam logic [11:0] c_REG_RX   = 12'h10C;
   localparam logic [11:0] c_REG_PIRQ = 12'h120;

   localparam logic [7:0] c_OP_DEVID  = 8'h01;
   localparam logic [7:0] c_OP_ADDR   = 8'h04;
   localparam logic [7:0] c_OP_WDATA  = 8'h08;
   localparam logic [7:0] c_OP_WLAST  = 8'h10;
   localparam logic [7:0] c_OP_READ   = 8'h20;
   localparam logic [7:0] c_OP_FINISH = 8'h80;

   typedef enum logic [4:0] {
      S_IDLE, S_FETCH, S_DECODE,
      S_ISR_RD, S_ISR_WR, S_PIRQ_WR, S_TX_DEV, S_TX_REG, S_CR_START,
      S_WPOLL, S_WTX, S_CPOLL_HI, S_CPOLL_LO, S_CR_STOP,
      S_RTX_DEV, S_RTX_CNT, S_CR_RD, S_RPOLL, S_RXRD,
      S_CR_ERR, S_DELAY, S_DONE, S_ERROR
   } state_t;

   state_t                    r_state, w_next, w_poll_exit;
   logic [CMD_ADDR_WIDTH-1:0] r_cmd_addr;
   logic [7:0]                r_devid, r_regaddr, r_byte, r_rcnt, r_rd_data, r_xfer;
   logic                      r_last, r_rd_valid;
   logic [c_POLL_W-1:0]       r_poll_cnt;
   logic [c_DLY_W-1:0]        r_dly;
   logic [1:0]                r_err_code, r_err_pend;
   logic                      r_wr_req, r_rd_req;
   logic [AXI_ADDR_WIDTH-1:0] r_addr;
   logic [AXI_DATA_WIDTH-1:0] r_wdata;

   logic                      w_go, w_adv, w_start, w_xfer_inc, w_poll_ok, w_poll_last;
   logic                      w_req_wr, w_req_rd;
   logic [11:0]               w_req_reg;
   logic [AXI_DATA_WIDTH-1:0] w_req_data;
   logic [7:0]                w_opcode, w_operand;
   logic                      w_ack;
   logic [AXI_DATA_WIDTH-1:0] w_rdata;

   assign w_opcode    = cmd_data[15:8];
   assign w_operand   = cmd_data[7:0];
   assign w_ack       = axi.seq_axi_ack;
   assign w_rdata     = axi.seq_axi_rdata;
   assign w_poll_last = (r_poll_cnt == c_POLL_W'(POLL_LIMIT - 1));

   // Success condition and exit target of whichever SR poll loop is active.
   always_comb begin
      w_poll_ok   = 1'b0;
      w_poll_exit = S_IDLE;
      case (r_state)
         S_WPOLL:    begin w_poll_ok = ~w_rdata[4]; w_poll_exit = S_WTX;      end
         S_CPOLL_HI: begin w_poll_ok =  w_rdata[2]; w_poll_exit = S_CPOLL_LO; end
         S_CPOLL_LO: begin w_poll_ok = ~w_rdata[2]; w_poll_exit = S_CR_STOP;  end
         S_RPOLL:    begin w_poll_ok = ~w_rdata[6]; w_poll_exit = S_RXRD;     end
         default:    ;
      endcase
   end

   // w_go marks every state entry, including re-entry of a poll state.
   always_comb begin
      w_next     = r_state;
      w_go       = 1'b0;
      w_adv      = 1'b0;
      w_start    = 1'b0;
      w_xfer_inc = 1'b0;
      case (r_state)
         S_IDLE, S_DONE, S_ERROR:
            if (start_pulse) begin w_next = S_FETCH; w_go = 1'b1; w_start = 1'b1; end
         S_FETCH: begin w_next = S_DECODE; w_go = 1'b1; end
         S_DECODE: begin
            w_go = 1'b1;
            case (w_opcode)
               c_OP_DEVID:             begin w_next = S_FETCH; w_adv = 1'b1; end
               c_OP_ADDR:              w_next = S_ISR_RD;
               c_OP_WDATA, c_OP_WLAST: w_next = S_WPOLL;
               c_OP_READ:              w_next = S_RTX_DEV;
               c_OP_FINISH:            w_next = S_DONE;
               default:                w_next = S_ERROR;
            endcase
         end
         S_ISR_RD:  if (w_ack) begin w_next = S_ISR_WR;  w_go = 1'b1; end
         S_ISR_WR:  if (w_ack) begin w_next = S_PIRQ_WR; w_go = 1'b1; end
         S_PIRQ_WR: if (w_ack) begin w_next = S_TX_DEV;  w_go = 1'b1; end
         S_TX_DEV:  if (w_ack) begin w_next = S_TX_REG;  w_go = 1'b1; end
         S_TX_REG:  if (w_ack) begin w_next = S_CR_START; w_go = 1'b1; end
         S_CR_START: if (w_ack) begin w_next = S_FETCH; w_go = 1'b1; w_adv = 1'b1; end
         S_WPOLL, S_CPOLL_HI, S_CPOLL_LO, S_RPOLL:
            if (w_ack) begin
               w_go = 1'b1;
               if (w_poll_ok)        w_next = w_poll_exit;
               else if (w_poll_last) w_next = S_CR_ERR;
               else                  w_next = r_state;
            end
         S_WTX:
            if (w_ack) begin
               w_go = 1'b1;
               if (r_last) w_next = S_CPOLL_HI;
               else begin w_next = S_FETCH; w_adv = 1'b1; end
            end
         S_CR_STOP: if (w_ack) begin w_next = S_DELAY; w_go = 1'b1; w_xfer_inc = 1'b1; end
         S_RTX_DEV: if (w_ack) begin w_next = S_RTX_CNT; w_go = 1'b1; end
         S_RTX_CNT: if (w_ack) begin w_next = S_CR_RD;   w_go = 1'b1; end
         S_CR_RD:   if (w_ack) begin w_next = S_RPOLL;   w_go = 1'b1; end
         S_RXRD:
            if (w_ack) begin
               w_go   = 1'b1;
               w_next = (r_rcnt == 8'd1) ? S_CR_STOP : S_RPOLL;
            end
         S_CR_ERR: if (w_ack) begin w_next = S_ERROR; w_go = 1'b1; end
         S_DELAY:
            if (r_dly == '0) begin w_next = S_FETCH; w_go = 1'b1; w_adv = 1'b1; end
         default: begin w_next = S_IDLE; w_go = 1'b1; end
      endcase
   end

   // Register access launched on entry to the next state.
   always_comb begin
      w_req_wr   = 1'b0;
      w_req_rd   = 1'b0;
      w_req_reg  = 12'h000;
      w_req_data = '0;
      case (w_next)
         S_ISR_RD:  begin w_req_rd = 1'b1; w_req_reg = c_REG_ISR; end
         S_ISR_WR:  begin w_req_wr = 1'b1; w_req_reg = c_REG_ISR; w_req_data = w_rdata; end
         S_PIRQ_WR: begin w_req_wr = 1'b1; w_req_reg = c_REG_PIRQ; end
         S_TX_DEV:  begin w_req_wr = 1'b1; w_req_reg = c_REG_TX;
                          w_req_data = AXI_DATA_WIDTH'({2'b01, r_devid}); end
         S_TX_REG:  begin w_req_wr = 1'b1; w_req_reg = c_REG_TX;
                          w_req_data = AXI_DATA_WIDTH'(r_regaddr); end
         S_CR_START: begin w_req_wr = 1'b1; w_req_reg = c_REG_CR;
                          w_req_data = AXI_DATA_WIDTH'(8'h05); end
         S_WTX:     begin w_req_wr = 1'b1; w_req_reg = c_REG_TX;
                          w_req_data = AXI_DATA_WIDTH'({r_last, 1'b0, r_byte}); end
         S_WPOLL, S_CPOLL_HI, S_CPOLL_LO, S_RPOLL:
                    begin w_req_rd = 1'b1; w_req_reg = c_REG_SR; end
         S_CR_STOP, S_CR_ERR:
                    begin w_req_wr = 1'b1; w_req_reg = c_REG_CR;
                          w_req_data = AXI_DATA_WIDTH'(8'h01); end
         S_RTX_DEV: begin w_req_wr = 1'b1; w_req_reg = c_REG_TX;
                          w_req_data = AXI_DATA_WIDTH'({2'b01, r_devid | 8'h01}); end
         S_RTX_CNT: begin w_req_wr = 1'b1; w_req_reg = c_REG_TX;
                          w_req_data = AXI_DATA_WIDTH'({2'b10, r_rcnt}); end
         S_CR_RD:   begin w_req_wr = 1'b1; w_req_reg = c_REG_CR;
                          w_req_data = AXI_DATA_WIDTH'(8'h0D); end
         S_RXRD:    begin w_req_rd = 1'b1; w_req_reg = c_REG_RX; end
         default:   ;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state    <= S_IDLE;
         r_cmd_addr <= '0;
         r_devid    <= '0;
         r_regaddr  <= '0;
         r_byte     <= '0;
         r_last     <= 1'b0;
         r_rcnt     <= '0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_xfer     <= '0;
         r_poll_cnt <= '0;
         r_dly      <= '0;
         r_err_code <= '0;
         r_err_pend <= '0;
         r_wr_req   <= 1'b0;
         r_rd_req   <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         r_state  <= w_next;
         r_wr_req <= w_go & w_req_wr;
         r_rd_req <= w_go & w_req_rd;
         if (w_go && (w_req_wr || w_req_rd)) begin
            r_addr  <= AXI_ADDR_WIDTH'(w_req_reg);
            r_wdata <= w_req_data;
         end

         r_rd_valid <= (r_state == S_RXRD) && w_ack;
         if (r_state == S_RXRD && w_ack) begin
            r_rd_data <= w_rdata[7:0];
            r_rcnt    <= r_rcnt - 8'd1;
         end

         if (w_start)     r_cmd_addr <= start_addr;
         else if (w_adv)  r_cmd_addr <= r_cmd_addr + CMD_ADDR_WIDTH'(1);
         if (w_xfer_inc)  r_xfer <= r_xfer + 8'd1;

         // Poll counter restarts whenever a different state is entered.
         if (w_go) r_poll_cnt <= (w_next == r_state) ? r_poll_cnt + c_POLL_W'(1) : '0;

         if (w_go && w_next == S_DELAY)        r_dly <= c_DLY_W'(DELAY_CYCLES - 1);
         else if (r_state == S_DELAY && r_dly != '0) r_dly <= r_dly - c_DLY_W'(1);

         if (r_state == S_DECODE) begin
            case (w_opcode)
               c_OP_DEVID: r_devid   <= w_operand;
               c_OP_ADDR:  r_regaddr <= w_operand;
               c_OP_WDATA: begin r_byte <= w_operand; r_last <= 1'b0; end
               c_OP_WLAST: begin r_byte <= w_operand; r_last <= 1'b1; end
               c_OP_READ:  r_rcnt <= (w_operand == 8'd0) ? 8'd1 : w_operand;
               default:    ;
            endcase
         end

         if (w_go && w_next == S_CR_ERR) r_err_pend <= (r_state == S_RPOLL) ? 2'd3 : 2'd2;
         if (w_start)                                        r_err_code <= 2'd0;
         else if (r_state == S_DECODE && w_next == S_ERROR)  r_err_code <= 2'd1;
         else if (r_state == S_CR_ERR && w_next == S_ERROR)  r_err_code <= r_err_pend;
      end
   end

   assign axi.seq_axi_wr_req = r_wr_req;
   assign axi.seq_axi_rd_req = r_rd_req;
   assign axi.seq_axi_addr   = r_addr;
   assign axi.seq_axi_wdata  = r_wdata;
   assign cmd_addr   = r_cmd_addr;
   assign rd_valid   = r_rd_valid;
   assign rd_data    = r_rd_data;
   assign busy       = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
   assign done       = (r_state == S_DONE);
   assign error      = (r_state == S_ERROR);
   assign err_code   = r_err_code;
   assign xfer_count = r_xfer;

endmodule
`default_nettype wire
